// File: rtl/adder_requester_if.sv
// Handshake bundle between the adder traffic requester (master) and the adder (slave).
interface adder_requester_if #(parameter int DATA_WIDTH = 4);
    logic                  req_val;
    logic                  req_rdy;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  rsp_val;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_s;
    logic                  rsp_c;

    modport master (output req_val, req_a, req_b, rsp_rdy,
                    input  req_rdy, rsp_val, rsp_s, rsp_c);
    modport slave  (input  req_val, req_a, req_b, rsp_rdy,
                    output req_rdy, rsp_val, rsp_s, rsp_c);
endinterface

// File: rtl/adder_requester.sv
// Traffic source/checker for the valid/ready adder: issues stepped operand pairs, checks {C,S}.
// Optional watchdog enabled by defining ADDER_REQ_TIMEOUT_EN.
module adder_requester #(
    parameter int DATA_WIDTH  = 4,
    parameter int CNT_W       = 8,
    parameter int EXP_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      count_i,
    input  logic [DATA_WIDTH-1:0] a_init_i,
    input  logic [DATA_WIDTH-1:0] b_init_i,
    input  logic [DATA_WIDTH-1:0] a_step_i,
    input  logic [DATA_WIDTH-1:0] b_step_i,
    adder_requester_if.master     bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      err_cnt_o,
    output logic [CNT_W-1:0]      sent_cnt_o,
    output logic [CNT_W-1:0]      recv_cnt_o,
    output logic                  timeout_o
);
    localparam int PW = $clog2(EXP_DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] a_step_q, a_step_d, b_step_q, b_step_d;
    logic [DATA_WIDTH-1:0] req_a_q, req_a_d, req_b_q, req_b_d;
    logic                  req_val_q, req_val_d;
    logic [CNT_W-1:0]      sent_q, sent_d, recv_q, recv_d, err_q, err_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [DATA_WIDTH:0]   fifo_q [EXP_DEPTH];
    logic [DATA_WIDTH:0]   sum_w;
    logic                  rsp_rdy_w, xfer, acc, wd_fire;

    assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o     = (state_q == S_DONE);
    assign rsp_rdy_w  = busy_o && (occ_q != '0);
    assign xfer       = req_val_q && bus.req_rdy;
    assign acc        = rsp_rdy_w && bus.rsp_val;
    assign sum_w      = {1'b0, req_a_q} + {1'b0, req_b_q};

    assign bus.req_val = req_val_q;
    assign bus.req_a   = req_a_q;
    assign bus.req_b   = req_b_q;
    assign bus.rsp_rdy = rsp_rdy_w;
    assign err_cnt_o   = err_q;
    assign sent_cnt_o  = sent_q;
    assign recv_cnt_o  = recv_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_step_d  = a_step_q;
        b_step_d  = b_step_q;
        req_a_d   = req_a_q;
        req_b_d   = req_b_q;
        req_val_d = req_val_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        err_d     = err_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d  = count_i;
                    a_step_d = a_step_i;
                    b_step_d = b_step_i;
                    req_a_d  = a_init_i;
                    req_b_d  = b_init_i;
                    sent_d   = '0;
                    recv_d   = '0;
                    err_d    = '0;
                    state_d  = (count_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (xfer) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    sent_d   = sent_q + 1'b1;
                    req_a_d  = req_a_q + a_step_q;
                    req_b_d  = req_b_q + b_step_q;
                end
                if (acc) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    recv_d   = recv_q + 1'b1;
                    if (({bus.rsp_c, bus.rsp_s} != fifo_q[rd_ptr_q]) && (err_q != '1))
                        err_d = err_q + 1'b1;
                end
                occ_d = occ_q + OW'(xfer) - OW'(acc);
                // A stalled request must stay up; otherwise re-arm only while credit remains.
                if (req_val_q && !xfer)
                    req_val_d = 1'b1;
                else
                    req_val_d = (state_q == S_RUN) && (sent_d < count_q) &&
                                (occ_d < OW'(EXP_DEPTH));
                if (sent_d == count_q)
                    state_d = (recv_d == count_q) ? S_DONE : S_DRAIN;
                if (wd_fire) begin
                    state_d   = S_DONE;
                    req_val_d = 1'b0;
                    occ_d     = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            a_step_q  <= '0;
            b_step_q  <= '0;
            req_a_q   <= '0;
            req_b_q   <= '0;
            req_val_q <= 1'b0;
            sent_q    <= '0;
            recv_q    <= '0;
            err_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            a_step_q  <= a_step_d;
            b_step_q  <= b_step_d;
            req_a_q   <= req_a_d;
            req_b_q   <= req_b_d;
            req_val_q <= req_val_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EXP_DEPTH; i++) fifo_q[i] <= '0;
        end else if (xfer) begin
            fifo_q[wr_ptr_q] <= sum_w;
        end
    end

`ifdef ADDER_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    // Fires on the TIMEOUT_CYC-th consecutive busy cycle with no handshake on either side.
    assign wd_fire   = busy_o && !xfer && !acc && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            wd_q      <= '0;
            timeout_q <= 1'b1;
        end else if (!busy_o || xfer || acc) begin
            wd_q      <= '0;
        end else begin
            wd_q      <= wd_q + 1'b1;
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_adder_requester.sv
// Bench for adder_requester: behavioural adder with optional corruption plus a pair/timing model.
module tb_adder_requester;
    localparam int DW = 4, CW = 8, DEPTH = 4, TMO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start;
    logic [CW-1:0] count;
    logic [DW-1:0] a_init, b_init, a_step, b_step;
    logic          busy, done, timeout;
    logic [CW-1:0] err_cnt, sent_cnt, recv_cnt;

    adder_requester_if #(.DATA_WIDTH(DW)) bus();

    adder_requester #(.DATA_WIDTH(DW), .CNT_W(CW), .EXP_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start_i(start), .count_i(count),
        .a_init_i(a_init), .b_init_i(b_init), .a_step_i(a_step), .b_step_i(b_step),
        .bus(bus), .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt),
        .sent_cnt_o(sent_cnt), .recv_cnt_o(recv_cnt), .timeout_o(timeout)
    );

    int total = 0, bad = 0;

    // Behavioural adder: unbounded result FIFO, response number corrupt_n gets +1.
    logic          rsp_en;
    int            corrupt_n;
    logic [DW:0]   afifo [64];
    int            awr, ard;
    logic [DW:0]   rsp_word;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awr <= 0;
            ard <= 0;
        end else begin
            if (bus.req_val && bus.req_rdy) begin
                afifo[awr % 64] <= {1'b0, bus.req_a} + {1'b0, bus.req_b};
                awr <= awr + 1;
            end
            if (bus.rsp_val && bus.rsp_rdy) ard <= ard + 1;
        end
    end
    assign rsp_word    = afifo[ard % 64] + (DW+1)'((ard == corrupt_n) ? 1 : 0);
    assign bus.rsp_val = rsp_en && (awr != ard);
    assign {bus.rsp_c, bus.rsp_s} = rsp_word;

    // Run model state
    int m_cnt, m_ai, m_bi, m_as, m_bs;
    int req_idx, rsp_idx, done_n, done_first_n, last_rsp_n, last_req_n, ncyc;
    int rdy_mode, rsp_mode;   // 0 off, 1 on, 2 random
    logic stall_prev, tmo_run;
    logic [DW-1:0] stall_a, stall_b;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int ma(int k); return (m_ai + k * m_as) % (1 << DW); endfunction
    function automatic int mb(int k); return (m_bi + k * m_bs) % (1 << DW); endfunction

    function automatic logic pick(int mode);
        return (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode == 1);
    endfunction

    task automatic cyc();
        @(negedge clk);
        ncyc++;
        if (stall_prev) begin
            chk("hold_val", bus.req_val, 1);
            chk("hold_a", bus.req_a, stall_a);
            chk("hold_b", bus.req_b, stall_b);
        end
        stall_prev = bus.req_val && !bus.req_rdy;
        stall_a = bus.req_a;
        stall_b = bus.req_b;
        if (bus.req_val && bus.req_rdy) begin
            chk("req_a", bus.req_a, ma(req_idx));
            chk("req_b", bus.req_b, mb(req_idx));
            req_idx++;
            last_req_n = ncyc;
        end
        if (bus.rsp_val && bus.rsp_rdy) begin
            rsp_idx++;
            last_rsp_n = ncyc;
        end
        if (int'(sent_cnt) - int'(recv_cnt) > DEPTH) chk("outstanding", int'(sent_cnt) - int'(recv_cnt), DEPTH);
        if (done) begin
            if (done_n == 0) done_first_n = ncyc;
            done_n++;
            if (m_cnt != 0 && !tmo_run) chk("done_lat", ncyc - last_rsp_n, 1);
        end
        @(posedge clk);
        #1;
        bus.req_rdy = pick(rdy_mode);
        rsp_en      = pick(rsp_mode);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1; start = 1'b0; bus.req_rdy = 1'b0; rsp_en = 1'b0;
        rdy_mode = 0; rsp_mode = 0; corrupt_n = -1; tmo_run = 1'b0; stall_prev = 1'b0;
        #1;
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_req_val", bus.req_val, 0); chk("rst_rsp_rdy", bus.rsp_rdy, 0);
        chk("rst_req_a", bus.req_a, 0); chk("rst_req_b", bus.req_b, 0);
        chk("rst_err", err_cnt, 0);     chk("rst_sent", sent_cnt, 0);
        chk("rst_recv", recv_cnt, 0);   chk("rst_timeout", timeout, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(int c, int ai, int bi, int as, int bs);
        m_cnt = c; m_ai = ai; m_bi = bi; m_as = as; m_bs = bs;
        req_idx = 0; rsp_idx = 0; done_n = 0; done_first_n = 0;
        last_rsp_n = 0; last_req_n = 0; stall_prev = 1'b0;
        count = CW'(c); a_init = DW'(ai); b_init = DW'(bi); a_step = DW'(as); b_step = DW'(bs);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (done_n > 0) break;
        end
        chk("done_in_time", done_n > 0, 1);
        repeat (2) cyc();
        chk("done_pulses", done_n, 1);
    endtask

    typedef struct {
        int cnt, ai, bi, as, bs, rdy, rsp, corr, exp_err;
    } vec_t;
    vec_t vecs[8];

    initial begin
        logic [DW-1:0] a0, b0;
        ncyc = 0;
        vecs[0] = '{3, 1, 2, 1, 1, 1, 1, -1, 0};
        vecs[1] = '{2, 15, 1, 1, 0, 1, 1, -1, 0};
        vecs[2] = '{4, 0, 0, 3, 5, 2, 2, 1, 1};
        vecs[3] = '{9, 14, 13, 15, 15, 2, 1, -1, 0};
        for (int i = 4; i < 8; i++) begin
            vecs[i].cnt = int'($urandom_range(1, 24));
            vecs[i].ai  = int'($urandom_range(0, 15));
            vecs[i].bi  = int'($urandom_range(0, 15));
            vecs[i].as  = int'($urandom_range(0, 15));
            vecs[i].bs  = int'($urandom_range(0, 15));
            vecs[i].rdy = int'($urandom_range(1, 2));
            vecs[i].rsp = int'($urandom_range(1, 2));
            vecs[i].corr = int'($urandom_range(0, vecs[i].cnt + 3));
            vecs[i].exp_err = (vecs[i].corr < vecs[i].cnt) ? 1 : 0;
        end

        for (int v = 0; v < 8; v++) begin
            do_reset();
            rdy_mode = vecs[v].rdy; rsp_mode = vecs[v].rsp; corrupt_n = vecs[v].corr;
            begin_run(vecs[v].cnt, vecs[v].ai, vecs[v].bi, vecs[v].as, vecs[v].bs);
            wait_done(3000);
            chk($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
            chk($sformatf("v%0d_sent", v), sent_cnt, vecs[v].cnt);
            chk($sformatf("v%0d_recv", v), recv_cnt, vecs[v].cnt);
            chk($sformatf("v%0d_reqs", v), req_idx, vecs[v].cnt);
            chk($sformatf("v%0d_rsps", v), rsp_idx, vecs[v].cnt);
            chk($sformatf("v%0d_busy", v), busy, 0);
            chk($sformatf("v%0d_timeout", v), timeout, 0);
        end

        // Backpressure: operands held while stalled, then queue depth limits outstanding requests.
        do_reset();
        rdy_mode = 0; rsp_mode = 0;
        begin_run(10, 5, 9, 2, 3);
        for (int i = 0; i < 10 && !bus.req_val; i++) cyc();
        chk("stall_val", bus.req_val, 1);
        a0 = bus.req_a; b0 = bus.req_b;
        chk("stall_a0", a0, 5);
        chk("stall_b0", b0, 9);
        repeat (5) cyc();
        chk("stall_a_end", bus.req_a, a0);
        chk("stall_b_end", bus.req_b, b0);
        rdy_mode = 1;
        repeat (20) cyc();
        chk("full_sent", sent_cnt, DEPTH);
        chk("full_req_val", bus.req_val, 0);
        rsp_mode = 1;
        wait_done(500);
        chk("bp_err", err_cnt, 0);
        chk("bp_recv", recv_cnt, 10);

        // Zero-length run.
        do_reset();
        rdy_mode = 1; rsp_mode = 1;
        begin_run(0, 3, 3, 1, 1);
        chk("cnt0_done", done, 1);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_req_val", bus.req_val, 0);
        cyc();
        chk("cnt0_done_drop", done, 0);
        chk("cnt0_busy2", busy, 0);
        chk("cnt0_pulses", done_n, 1);
        chk("cnt0_reqs", req_idx, 0);

        // Reset in the middle of a run, then a clean follow-up run.
        do_reset();
        rdy_mode = 1; rsp_mode = 1;
        begin_run(5, 2, 6, 1, 1);
        for (int i = 0; i < 50 && sent_cnt < 2; i++) cyc();
        chk("mid_sent", sent_cnt, 2);
        do_reset();
        rdy_mode = 1; rsp_mode = 1;
        begin_run(2, 8, 8, 4, 4);
        wait_done(200);
        chk("post_rst_err", err_cnt, 0);
        chk("post_rst_recv", recv_cnt, 2);

`ifdef ADDER_REQ_TIMEOUT_EN
        // Responses never arrive: watchdog ends the run.
        do_reset();
        rdy_mode = 1; rsp_mode = 0; tmo_run = 1'b1;
        begin_run(2, 1, 1, 1, 1);
        for (int i = 0; i < 300 && done_n == 0; i++) cyc();
        chk("tmo_done_seen", done_n > 0, 1);
        chk("tmo_gap", done_first_n - last_req_n, TMO + 1);
        chk("tmo_flag", timeout, 1);
        chk("tmo_sent", sent_cnt, 2);
        chk("tmo_recv", recv_cnt, 0);
        repeat (3) cyc();
        chk("tmo_held", timeout, 1);
        chk("tmo_rsp_rdy", bus.rsp_rdy, 0);
        chk("tmo_req_val", bus.req_val, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_time_limit: got expired want finished");
        $fatal(1);
    end
endmodule
